// File: rtl/pll_reconf_pkg.sv
// -----------------------------------------------------------------------------
// pll_reconf_pkg
// Shared definitions for the video PLL reconfiguration scheduler:
//   - PLL scheme width and the eight named scheme codes
//   - sequencer FSM state type
//   - requester identity type
//   - width of the shared timeout/settle timer
// -----------------------------------------------------------------------------
package pll_reconf_pkg;

    localparam int unsigned PLL_STATE_W = 3;
    localparam int unsigned TIMER_W     = 20;

    typedef logic [PLL_STATE_W-1:0] pll_scheme_t;

    localparam pll_scheme_t PLL_SCHEME_0 = 3'd0;
    localparam pll_scheme_t PLL_SCHEME_1 = 3'd1;
    localparam pll_scheme_t PLL_SCHEME_2 = 3'd2;
    localparam pll_scheme_t PLL_SCHEME_3 = 3'd3;
    localparam pll_scheme_t PLL_SCHEME_4 = 3'd4;
    localparam pll_scheme_t PLL_SCHEME_5 = 3'd5;
    localparam pll_scheme_t PLL_SCHEME_6 = 3'd6;
    localparam pll_scheme_t PLL_SCHEME_7 = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_SETTLE = 2'd3
    } sched_state_e;

    typedef enum logic {
        SRC_KBD = 1'b0,
        SRC_REG = 1'b1
    } req_src_e;

endpackage

// File: rtl/pll_req_slot.sv
// -----------------------------------------------------------------------------
// pll_req_slot
// One pending-request slot: a valid bit plus the requested PLL scheme.
// A request overwrites the stored target (last request wins); a grant clears
// valid; a request in the same cycle as a grant leaves the slot valid with the
// new target.
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset (slot empty)
//   req_i     in   request pulse
//   target_i  in   requested scheme, qualified by req_i
//   grant_i   in   slot consumed by the arbiter this cycle
//   valid_o   out  slot holds a pending request
//   target_o  out  pending target scheme
// -----------------------------------------------------------------------------
module pll_req_slot
    import pll_reconf_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_i,
    input  logic [PLL_STATE_W-1:0] target_i,
    input  logic                   grant_i,
    output logic                   valid_o,
    output logic [PLL_STATE_W-1:0] target_o
);

    logic        valid_q,  valid_d;
    pll_scheme_t target_q, target_d;

    always_comb begin
        valid_d  = valid_q;
        target_d = target_q;
        if (grant_i) begin
            valid_d = 1'b0;
        end
        // Applied after the grant so a fresh request survives its own grant.
        if (req_i) begin
            valid_d  = 1'b1;
            target_d = target_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            target_q <= '0;
        end else begin
            valid_q  <= valid_d;
            target_q <= target_d;
        end
    end

    assign valid_o  = valid_q;
    assign target_o = target_q;

endmodule

// File: rtl/pll_reconf_sched.sv
// -----------------------------------------------------------------------------
// pll_reconf_sched
// Arbitrates PLL mode-change requests from the register port (high priority)
// and the keyboard (low priority), issues one SSTEP per applied change, waits
// for SRDY with a timeout, then holds off for a settle interval before the
// next change. A request for the scheme already in use retires at once.
//
// Parameters:
//   TIMEOUT_CYC    cycles to wait for SRDY after SSTEP
//   SETTLE_CYC     idle cycles after each completion
//   DEFAULT_STATE  cur_state / pll_state after reset
//
// Ports:
//   clk, rst       clock (pll_top CLKIN) and synchronous active-high reset
//   kbd_req/state  keyboard request pulse and target scheme
//   reg_req/state  register-port request pulse and target scheme
//   kbd_done       one-cycle pulse when the keyboard request retires
//   reg_done       one-cycle pulse when the register request retires
//   sstep          one-cycle SSTEP pulse to pll_top
//   pll_state      STATE to pll_top, stable from SSTEP until retire
//   srdy           SRDY from pll_top
//   busy           high whenever the sequencer is not idle
//   cur_state      last successfully applied scheme
//   timeout_err    sticky: last attempted change timed out
// -----------------------------------------------------------------------------
module pll_reconf_sched
    import pll_reconf_pkg::*;
#(
    parameter int unsigned                TIMEOUT_CYC   = 1048575,
    parameter int unsigned                SETTLE_CYC    = 1024,
    parameter logic [PLL_STATE_W-1:0]     DEFAULT_STATE = 3'd0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   kbd_req,
    input  logic [PLL_STATE_W-1:0] kbd_state,
    input  logic                   reg_req,
    input  logic [PLL_STATE_W-1:0] reg_state,
    output logic                   kbd_done,
    output logic                   reg_done,
    output logic                   sstep,
    output logic [PLL_STATE_W-1:0] pll_state,
    input  logic                   srdy,
    output logic                   busy,
    output logic [PLL_STATE_W-1:0] cur_state,
    output logic                   timeout_err
);

    localparam int unsigned TIMER_MAX = (1 << TIMER_W) - 1;
    localparam logic [TIMER_W-1:0] TMO_LIM =
        TIMER_W'((TIMEOUT_CYC > TIMER_MAX) ? TIMER_MAX : TIMEOUT_CYC);
    localparam logic [TIMER_W-1:0] STL_LIM =
        TIMER_W'((SETTLE_CYC > TIMER_MAX) ? TIMER_MAX : SETTLE_CYC);

    // Pending request slots
    logic        kbd_vld, reg_vld;
    pll_scheme_t kbd_tgt, reg_tgt;
    logic        grant_kbd, grant_reg;

    pll_req_slot u_kbd_slot (
        .clk      (clk),
        .rst      (rst),
        .req_i    (kbd_req),
        .target_i (kbd_state),
        .grant_i  (grant_kbd),
        .valid_o  (kbd_vld),
        .target_o (kbd_tgt)
    );

    pll_req_slot u_reg_slot (
        .clk      (clk),
        .rst      (rst),
        .req_i    (reg_req),
        .target_i (reg_state),
        .grant_i  (grant_reg),
        .valid_o  (reg_vld),
        .target_o (reg_tgt)
    );

    // Sequencer state
    sched_state_e         state_q,     state_d;
    logic [TIMER_W-1:0]   timer_q,     timer_d;
    req_src_e             src_q,       src_d;
    pll_scheme_t          pll_state_q, pll_state_d;
    pll_scheme_t          cur_state_q, cur_state_d;
    logic                 sstep_q,     sstep_d;
    logic                 err_q,       err_d;
    logic                 busy_q,      busy_d;
    logic                 kbd_done_q,  kbd_done_d;
    logic                 reg_done_q,  reg_done_d;

    req_src_e             gnt_src;
    pll_scheme_t          gnt_tgt;
    logic                 retire;
    req_src_e             retire_src;

    always_comb begin
        state_d     = state_q;
        // One timer serves both the SRDY timeout and the settle count; it is
        // cleared on entry to ISSUE and to SETTLE and saturates otherwise.
        timer_d     = (timer_q == '1) ? timer_q : timer_q + 1'b1;
        src_d       = src_q;
        pll_state_d = pll_state_q;
        cur_state_d = cur_state_q;
        sstep_d     = 1'b0;
        err_d       = err_q;
        grant_kbd   = 1'b0;
        grant_reg   = 1'b0;
        gnt_src     = SRC_KBD;
        gnt_tgt     = kbd_tgt;
        retire      = 1'b0;
        retire_src  = src_q;

        unique case (state_q)
            S_IDLE: begin
                if (reg_vld || kbd_vld) begin
                    if (reg_vld) begin
                        grant_reg = 1'b1;
                        gnt_src   = SRC_REG;
                        gnt_tgt   = reg_tgt;
                    end else begin
                        grant_kbd = 1'b1;
                    end
                    if (gnt_tgt == cur_state_q) begin
                        retire     = 1'b1;
                        retire_src = gnt_src;
                    end else begin
                        pll_state_d = gnt_tgt;
                        src_d       = gnt_src;
                        timer_d     = '0;
                        sstep_d     = 1'b1;
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // SRDY is checked first so it wins over a simultaneous expiry.
                if (srdy) begin
                    cur_state_d = pll_state_q;
                    err_d       = 1'b0;
                    retire      = 1'b1;
                    timer_d     = '0;
                    state_d     = S_SETTLE;
                end else if (timer_q >= TMO_LIM) begin
                    err_d   = 1'b1;
                    retire  = 1'b1;
                    timer_d = '0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (timer_q >= STL_LIM) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        kbd_done_d = retire && (retire_src == SRC_KBD);
        reg_done_d = retire && (retire_src == SRC_REG);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            src_q       <= SRC_KBD;
            pll_state_q <= DEFAULT_STATE;
            cur_state_q <= DEFAULT_STATE;
            sstep_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            kbd_done_q  <= 1'b0;
            reg_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            src_q       <= src_d;
            pll_state_q <= pll_state_d;
            cur_state_q <= cur_state_d;
            sstep_q     <= sstep_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            kbd_done_q  <= kbd_done_d;
            reg_done_q  <= reg_done_d;
        end
    end

    assign sstep       = sstep_q;
    assign pll_state   = pll_state_q;
    assign cur_state   = cur_state_q;
    assign timeout_err = err_q;
    assign busy        = busy_q;
    assign kbd_done    = kbd_done_q;
    assign reg_done    = reg_done_q;

endmodule

// File: tb/tb_pll_reconf_sched.sv
// -----------------------------------------------------------------------------
// tb_pll_reconf_sched
// Scoreboard bench for pll_reconf_sched. Each scenario is a list of timed
// requests; a transaction-level model turns it into the expected sequence of
// SSTEP and done events (with cycle stamps), plus the SRDY delay used for each
// SSTEP. A responder answers SSTEP after that delay and a monitor compares
// every SSTEP/done the DUT shows against the head of the expected queue.
// -----------------------------------------------------------------------------
module tb_pll_reconf_sched;

    localparam int         TMO     = 50;
    localparam int         STL     = 8;
    localparam logic [2:0] DEF     = 3'd0;
    localparam int         NO_SRDY = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kbd_req = 1'b0, reg_req = 1'b0;
    logic [2:0] kbd_state = '0, reg_state = '0;
    logic       srdy_rsp = 1'b0, srdy_spur = 1'b0;
    logic       srdy;
    logic       kbd_done, reg_done, sstep, busy, timeout_err;
    logic [2:0] pll_state, cur_state;

    assign srdy = srdy_rsp | srdy_spur;

    pll_reconf_sched #(
        .TIMEOUT_CYC   (TMO),
        .SETTLE_CYC    (STL),
        .DEFAULT_STATE (DEF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .kbd_req     (kbd_req),
        .kbd_state   (kbd_state),
        .reg_req     (reg_req),
        .reg_state   (reg_state),
        .kbd_done    (kbd_done),
        .reg_done    (reg_done),
        .sstep       (sstep),
        .pll_state   (pll_state),
        .srdy        (srdy),
        .busy        (busy),
        .cur_state   (cur_state),
        .timeout_err (timeout_err)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         is_reg;
        logic [2:0] tgt;
    } req_t;

    // kind: 0 = sstep, 1 = kbd_done, 2 = reg_done
    typedef struct {
        int         cyc;
        int         kind;
        logic [2:0] pll;
        logic [2:0] cur;
        bit         err;
        bit         bsy;
    } ev_t;

    req_t       reqs[$];
    ev_t        exp_q[$];
    int         delays[$];
    int         forced[$];
    logic [2:0] m_cur = DEF;
    logic [2:0] m_pll = DEF;
    bit         m_err = 1'b0;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         base = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push_ev(input int c, input int kind, input logic [2:0] pll,
                           input logic [2:0] cur, input bit err, input bit bsy);
        ev_t e;
        e.cyc = c; e.kind = kind; e.pll = pll; e.cur = cur; e.err = err; e.bsy = bsy;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event_unexpected: got kind=%0d at cycle %0d pll=%0d, required no event",
                     kind, cyc, pll_state);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.cyc != cyc || pll_state !== e.pll || cur_state !== e.cur ||
            timeout_err !== e.err || busy !== e.bsy) begin
            n_fail++;
            $display("FAIL event: got kind=%0d cyc=%0d pll=%0d cur=%0d err=%0b busy=%0b, required kind=%0d cyc=%0d pll=%0d cur=%0d err=%0b busy=%0b",
                     kind, cyc, pll_state, cur_state, timeout_err, busy,
                     e.kind, e.cyc, e.pll, e.cur, e.err, e.bsy);
        end
    endtask

    // Monitor: every visible SSTEP or done pulse is one scoreboard comparison.
    always @(negedge clk) begin
        if (sstep === 1'b1)    check_ev(0);
        if (kbd_done === 1'b1) check_ev(1);
        if (reg_done === 1'b1) check_ev(2);
    end

    // SRDY responder: answers each SSTEP after the delay chosen by the model.
    initial begin : responder
        int k;
        forever begin
            @(negedge clk);
            if (sstep === 1'b1) begin
                k = (delays.size() == 0) ? NO_SRDY : delays.pop_front();
                if (k < NO_SRDY) begin
                    repeat (k) @(negedge clk);
                    srdy_rsp = 1'b1;
                    @(negedge clk);
                    srdy_rsp = 1'b0;
                end
            end
        end
    end

    // Transaction-level model. A request at cycle r is visible to the
    // arbiter at r+1; t is the next cycle the sequencer is idle and able to
    // evaluate the pending slots.
    task automatic model_run(output int last_t);
        bit         pv[2];
        logic [2:0] pt[2];
        int         t, idx, g, k, s, d;
        pv[0] = 1'b0; pv[1] = 1'b0; pt[0] = '0; pt[1] = '0;
        idx = 0;
        t = reqs[0].cyc + 1;
        while (1) begin
            while (idx < reqs.size() && reqs[idx].cyc < t) begin
                g = reqs[idx].is_reg ? 1 : 0;
                pv[g] = 1'b1;
                pt[g] = reqs[idx].tgt;
                idx++;
            end
            if (!pv[0] && !pv[1]) begin
                if (idx >= reqs.size()) break;
                t = reqs[idx].cyc + 1;
            end else begin
                g = pv[1] ? 1 : 0;
                pv[g] = 1'b0;
                if (pt[g] == m_cur) begin
                    push_ev(t + 1, (g == 1) ? 2 : 1, m_pll, m_cur, m_err, 1'b0);
                    t = t + 1;
                end else begin
                    s = t + 1;
                    m_pll = pt[g];
                    push_ev(s, 0, m_pll, m_cur, m_err, 1'b1);
                    if (forced.size() > 0)
                        k = forced.pop_front();
                    else if ($urandom_range(0, 9) == 0)
                        k = NO_SRDY;
                    else
                        k = int'($urandom_range(1, 55));
                    delays.push_back(k);
                    if (k >= 1 && k <= TMO) begin
                        d = s + k + 1;
                        m_cur = m_pll;
                        m_err = 1'b0;
                    end else begin
                        d = s + TMO + 1;
                        m_err = 1'b1;
                    end
                    push_ev(d, (g == 1) ? 2 : 1, m_pll, m_cur, m_err, 1'b1);
                    t = d + STL + 1;
                end
            end
        end
        last_t = t;
    endtask

    task automatic begin_scn();
        reqs.delete();
        forced.delete();
        @(negedge clk);
        base = cyc + 2;
    endtask

    task automatic add_req(input int off, input bit is_reg, input logic [2:0] tgt);
        req_t r;
        r.cyc = base + off; r.is_reg = is_reg; r.tgt = tgt;
        reqs.push_back(r);
    endtask

    task automatic run_scn(input string name);
        int last_t, i;
        model_run(last_t);
        i = 0;
        while (i < reqs.size()) begin
            @(negedge clk);
            kbd_req = 1'b0;
            reg_req = 1'b0;
            while (i < reqs.size() && reqs[i].cyc <= cyc) begin
                if (reqs[i].is_reg) begin
                    reg_req = 1'b1; reg_state = reqs[i].tgt;
                end else begin
                    kbd_req = 1'b1; kbd_state = reqs[i].tgt;
                end
                i++;
            end
        end
        @(negedge clk);
        kbd_req = 1'b0;
        reg_req = 1'b0;
        while (cyc < last_t + 4) @(negedge clk);
        chk({name, "_drain"}, exp_q.size(), 0);
        chk({name, "_busy"}, busy, 1'b0);
        chk({name, "_cur"}, cur_state, m_cur);
        chk({name, "_err"}, timeout_err, m_err);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

    initial begin : main
        int c;
        int n, off;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_sstep", sstep, 1'b0);
        chk("rst_pll_state", pll_state, DEF);
        chk("rst_cur_state", cur_state, DEF);
        chk("rst_busy", busy, 1'b0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        chk("rst_kbd_done", kbd_done, 1'b0);
        chk("rst_reg_done", reg_done, 1'b0);
        rst = 1'b0;

        // Target equal to current scheme: immediate retire
        begin_scn(); add_req(0, 1'b0, 3'd0); run_scn("same_target");

        // Basic keyboard change, SRDY 10 cycles after SSTEP
        begin_scn(); add_req(0, 1'b0, 3'd5); forced.push_back(10); run_scn("kbd_basic");

        // Simultaneous requests: register first, then keyboard
        begin_scn(); add_req(0, 1'b1, 3'd3); add_req(0, 1'b0, 3'd6);
        forced.push_back(10); forced.push_back(10); run_scn("priority");

        // No SRDY: timeout
        begin_scn(); add_req(0, 1'b0, 3'd1); forced.push_back(NO_SRDY); run_scn("timeout");

        // SRDY on the final timeout cycle wins and clears the error
        begin_scn(); add_req(0, 1'b0, 3'd4); forced.push_back(TMO); run_scn("srdy_at_limit");

        // Keyboard 2 then 7 while a register change waits for SRDY
        begin_scn(); add_req(0, 1'b1, 3'd2); add_req(4, 1'b0, 3'd2); add_req(8, 1'b0, 3'd7);
        forced.push_back(30); forced.push_back(5); run_scn("last_wins");

        // Request in the same cycle as its own grant
        begin_scn(); add_req(0, 1'b0, 3'd3); add_req(1, 1'b0, 3'd1);
        forced.push_back(5); forced.push_back(5); run_scn("set_over_clear");

        // SRDY one cycle too late: timeout, late SRDY ignored
        begin_scn(); add_req(0, 1'b0, 3'd6); forced.push_back(TMO + 1); run_scn("srdy_late");

        // Spurious SRDY while idle
        repeat (3) begin
            @(negedge clk); srdy_spur = 1'b1;
            @(negedge clk); srdy_spur = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("spurious_cur", cur_state, m_cur);
        chk("spurious_busy", busy, 1'b0);
        chk("spurious_err", timeout_err, m_err);

        // Randomized scenarios
        for (int s = 0; s < 25; s++) begin
            begin_scn();
            n = int'($urandom_range(1, 4));
            off = 0;
            for (int j = 0; j < n; j++) begin
                add_req(off, ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)));
                off += int'($urandom_range(0, 20));
            end
            run_scn("rand");
        end

        // Reset during WAIT_RDY, with a keyboard request pending
        @(negedge clk);
        c = cyc;
        kbd_req = 1'b1;
        kbd_state = m_cur + 3'd1;
        push_ev(c + 2, 0, kbd_state, m_cur, m_err, 1'b1);
        delays.push_back(20);
        @(negedge clk);
        kbd_req = 1'b0;
        while (cyc < c + 7) @(negedge clk);
        kbd_req = 1'b1;
        kbd_state = m_cur + 3'd2;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_sstep", sstep, 1'b0);
        chk("midrst_pll_state", pll_state, DEF);
        chk("midrst_cur_state", cur_state, DEF);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_timeout_err", timeout_err, 1'b0);
        chk("midrst_done", {kbd_done, reg_done}, 2'b00);
        kbd_req = 1'b0;
        rst = 1'b0;
        m_cur = DEF;
        m_pll = DEF;
        m_err = 1'b0;
        repeat (40) @(negedge clk);
        chk("midrst_after_cur", cur_state, DEF);
        chk("midrst_after_busy", busy, 1'b0);
        chk("midrst_after_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
